// File: rtl/hps_din_sequencer_if.sv
// Bus between the HPS PIO side, the MLP input buffer and the MLP core start/done
// handshake. The sequencer connects through the master modport and its
// environment through the slave modport.
interface hps_din_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] din;
  logic [7:0]        ctrl;
  logic [31:0]       status;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic              nn_start;
  logic              nn_done;

  modport master (
    input  din, ctrl, nn_done,
    output status, buf_we, buf_addr, buf_wdata, nn_start
  );

  modport slave (
    output din, ctrl, nn_done,
    input  status, buf_we, buf_addr, buf_wdata, nn_start
  );
endinterface

// File: rtl/hps_din_sequencer.sv
// Frame loader: HPS writes a word to the data PIO and toggles ctrl[0]; each
// accepted word goes to the MLP input buffer at an incrementing address and
// the ack bit in status toggles. After FRAME_LEN words nn_start pulses, and the
// block tracks the core until nn_done.
// Optional watchdog on the RUN state: define HPS_DIN_SEQ_TIMEOUT_EN.
module hps_din_sequencer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int FRAME_LEN   = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic                 clk,
  input logic                 reset,
  hps_din_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  // Reject parameter sets the counters cannot represent.
  if (FRAME_LEN < 1 || FRAME_LEN > (2 ** ADDR_W) || TIMEOUT_CYC < 1) begin : g_param_check
    $error("hps_din_sequencer: illegal FRAME_LEN/ADDR_W/TIMEOUT_CYC combination");
  end

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_cnt_reg, wr_cnt_next;
  logic              req_q_reg;
  logic              ack_reg, ack_next;
  logic              overflow_reg, overflow_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              buf_we_reg, buf_we_next;
  logic [ADDR_W-1:0] buf_addr_reg, buf_addr_next;
  logic [DATA_W-1:0] buf_wdata_reg, buf_wdata_next;
  logic              nn_start_reg, nn_start_next;
  logic              timeout_flag;

  logic              new_req;
  logic              clear;
  logic [ADDR_W-1:0] base_cnt;
  logic              unused_ctrl;

`ifdef HPS_DIN_SEQ_TIMEOUT_EN
  logic [31:0]       wd_reg, wd_next;
  logic              timeout_reg, timeout_next;
  assign timeout_flag = timeout_reg;
`else
  assign timeout_flag = 1'b0;
`endif

  // A toggle of ctrl[0] relative to the last sampled value is one request.
  assign new_req     = bus.ctrl[0] ^ req_q_reg;
  assign clear       = bus.ctrl[1];
  assign unused_ctrl = ^bus.ctrl[7:2];

  // A new frame started from DONE always begins at address 0.
  assign base_cnt = (state_reg == DONE) ? '0 : wr_cnt_reg;

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_next     = state_reg;
    wr_cnt_next    = wr_cnt_reg;
    ack_next       = ack_reg;
    overflow_next  = overflow_reg;
    buf_we_next    = 1'b0;
    buf_addr_next  = buf_addr_reg;
    buf_wdata_next = buf_wdata_reg;
    nn_start_next  = 1'b0;
`ifdef HPS_DIN_SEQ_TIMEOUT_EN
    wd_next        = wd_reg;
    timeout_next   = timeout_reg;
`endif

    if (clear) begin
      // Clear wins over a coincident request; the request is still consumed
      // because req_q tracks ctrl[0] unconditionally.
      state_next    = IDLE;
      wr_cnt_next   = '0;
      overflow_next = 1'b0;
`ifdef HPS_DIN_SEQ_TIMEOUT_EN
      timeout_next  = 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (new_req) begin
            buf_we_next    = 1'b1;
            buf_addr_next  = base_cnt;
            buf_wdata_next = bus.din;
            ack_next       = ~ack_reg;
            if (base_cnt == LAST_IDX) begin
              wr_cnt_next = '0;
              state_next  = START;
            end else begin
              wr_cnt_next = base_cnt + 1'b1;
              state_next  = IDLE;
            end
          end
        end
        START: begin
          // nn_done here is deliberately ignored: the core has not been started.
          nn_start_next = 1'b1;
          state_next    = RUN;
          if (new_req) overflow_next = 1'b1;
`ifdef HPS_DIN_SEQ_TIMEOUT_EN
          wd_next = '0;
`endif
        end
        RUN: begin
          if (new_req) overflow_next = 1'b1;
`ifdef HPS_DIN_SEQ_TIMEOUT_EN
          wd_next = wd_reg + 32'd1;
`endif
          if (bus.nn_done) begin
            state_next = DONE;
          end
`ifdef HPS_DIN_SEQ_TIMEOUT_EN
          else if (wd_next == 32'(TIMEOUT_CYC)) begin
            // Expiry only counts when the core did not finish on the same cycle.
            timeout_next = 1'b1;
            state_next   = DONE;
          end
`endif
        end
        default: state_next = IDLE;
      endcase
    end

    busy_next = (state_next == START) || (state_next == RUN);
    done_next = (state_next == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      wr_cnt_reg    <= '0;
      req_q_reg     <= 1'b0;
      ack_reg       <= 1'b0;
      overflow_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      buf_we_reg    <= 1'b0;
      buf_addr_reg  <= '0;
      buf_wdata_reg <= '0;
      nn_start_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_cnt_reg    <= wr_cnt_next;
      req_q_reg     <= bus.ctrl[0];
      ack_reg       <= ack_next;
      overflow_reg  <= overflow_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      buf_we_reg    <= buf_we_next;
      buf_addr_reg  <= buf_addr_next;
      buf_wdata_reg <= buf_wdata_next;
      nn_start_reg  <= nn_start_next;
    end
  end

`ifdef HPS_DIN_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else begin
      wd_reg      <= wd_next;
      timeout_reg <= timeout_next;
    end
  end
`endif

  // Low byte of the write counter for the status word, zero-extended if narrow.
  logic [7:0] cnt8;
  if (ADDR_W >= 8) begin : g_cnt_wide
    assign cnt8 = wr_cnt_reg[7:0];
  end else begin : g_cnt_narrow
    assign cnt8 = {{(8 - ADDR_W){1'b0}}, wr_cnt_reg};
  end

  assign bus.status    = {16'd0, cnt8, 3'd0, timeout_flag, overflow_reg,
                          done_reg, busy_reg, ack_reg};
  assign bus.buf_we    = buf_we_reg;
  assign bus.buf_addr  = buf_addr_reg;
  assign bus.buf_wdata = buf_wdata_reg;
  assign bus.nn_start  = nn_start_reg;

endmodule

// File: tb/tb_hps_din_sequencer.sv
// Directed bench for hps_din_sequencer with FRAME_LEN=4 and TIMEOUT_CYC=10.
// Expected buffer writes go into a scoreboard queue; a negedge monitor pops and
// compares each buf_we and checks the nn_start pulse that must follow a frame.
module tb_hps_din_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hps_din_sequencer_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  hps_din_sequencer #(
    .DATA_W(32), .ADDR_W(8), .FRAME_LEN(4), .TIMEOUT_CYC(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    bit          last;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  bit  exp_ack = 1'b0;
  bit  start_due = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end else begin
      $display("ok   %s 0x%08h", name, act);
    end
  endtask

  function automatic logic [31:0] st(input bit busy, input bit done, input bit ovf,
                                     input bit to, input logic [7:0] cnt);
    return {16'd0, cnt, 3'd0, to, ovf, done, busy, exp_ack};
  endfunction

  // One request toggle; an accepted word is pushed into the scoreboard.
  task automatic send(input logic [31:0] d, input bit accept, input logic [7:0] addr, input bit last);
    @(negedge clk);
    bus.din = d;
    bus.ctrl[0] = ~bus.ctrl[0];
    if (accept) begin
      exp_q.push_back('{addr: addr, data: d, last: last});
      exp_ack = ~exp_ack;
    end
    @(negedge clk);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    bus.nn_done = 1'b1;
    @(negedge clk);
    bus.nn_done = 1'b0;
  endtask

  task automatic pulse_clear(input bit with_req);
    @(negedge clk);
    bus.ctrl[1] = 1'b1;
    if (with_req) begin
      bus.din = 32'hCC;
      bus.ctrl[0] = ~bus.ctrl[0];
    end
    @(negedge clk);
    bus.ctrl[1] = 1'b0;
  endtask

  // Monitor: compare every buffer write and the nn_start that follows a frame.
  always @(negedge clk) begin
    if (!reset) begin
      if (start_due) begin
        checks++;
        if (bus.nn_start !== 1'b1) begin
          failures++;
          $display("FAIL nn_start_after_frame actual=%0b required=1", bus.nn_start);
        end else begin
          $display("ok   nn_start pulse");
        end
        start_due = 1'b0;
      end else if (bus.nn_start === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL nn_start_unexpected actual=1 required=0");
      end

      if (bus.buf_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL buf_write_unexpected actual=(%0d,0x%08h) required=none",
                   bus.buf_addr, bus.buf_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (bus.buf_addr !== e.addr || bus.buf_wdata !== e.data) begin
            failures++;
            $display("FAIL buf_write actual=(%0d,0x%08h) required=(%0d,0x%08h)",
                     bus.buf_addr, bus.buf_wdata, e.addr, e.data);
          end else begin
            $display("ok   buf_write (%0d,0x%08h)", bus.buf_addr, bus.buf_wdata);
          end
          if (e.last) start_due = 1'b1;
        end
      end
    end
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("FAIL sim_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    bus.din = '0;
    bus.ctrl = '0;
    bus.nn_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_status", bus.status, 32'd0);
    chk("rst_buf_we", {31'd0, bus.buf_we}, 32'd0);
    chk("rst_nn_start", {31'd0, bus.nn_start}, 32'd0);

    // Full frame of four words
    send(32'h11, 1, 0, 0); chk("w0_status", bus.status, st(0, 0, 0, 0, 8'd1));
    send(32'h22, 1, 1, 0); chk("w1_status", bus.status, st(0, 0, 0, 0, 8'd2));
    send(32'h33, 1, 2, 0); chk("w2_status", bus.status, st(0, 0, 0, 0, 8'd3));
    send(32'h44, 1, 3, 1); chk("w3_status_busy", bus.status, st(1, 0, 0, 0, 8'd0));
    @(negedge clk);
    chk("run_status", bus.status, st(1, 0, 0, 0, 8'd0));

    // Request during RUN sets overflow, then the core finishes
    send(32'h55, 0, 0, 0); chk("ovf_status", bus.status, st(1, 0, 1, 0, 8'd0));
    pulse_done();
    chk("done_status", bus.status, st(0, 1, 1, 0, 8'd0));

    // Request in DONE restarts at address 0
    send(32'hAA, 1, 0, 0); chk("from_done_status", bus.status, st(0, 0, 1, 0, 8'd1));
    send(32'hBB, 1, 1, 0); chk("second_word_status", bus.status, st(0, 0, 1, 0, 8'd2));

    // Clear with a simultaneous request: no write, ack kept, counters cleared
    pulse_clear(1);
    chk("clear_status", bus.status, st(0, 0, 0, 0, 8'd0));
    pulse_done();
    chk("done_in_idle_ignored", bus.status, st(0, 0, 0, 0, 8'd0));
    send(32'h77, 1, 0, 0); chk("after_clear_status", bus.status, st(0, 0, 0, 0, 8'd1));

    // Clear during RUN discards the core's later done
    send(32'h78, 1, 1, 0);
    send(32'h79, 1, 2, 0);
    send(32'h7A, 1, 3, 1);
    @(negedge clk);
    pulse_clear(0);
    chk("clear_in_run_status", bus.status, st(0, 0, 0, 0, 8'd0));
    pulse_done();
    chk("late_done_ignored", bus.status, st(0, 0, 0, 0, 8'd0));

`ifdef HPS_DIN_SEQ_TIMEOUT_EN
    // Watchdog expiry with nn_done withheld
    send(32'hA0, 1, 0, 0);
    send(32'hA1, 1, 1, 0);
    send(32'hA2, 1, 2, 0);
    send(32'hA3, 1, 3, 1);
    repeat (10) @(negedge clk);
    chk("wd_before_expiry", bus.status, st(1, 0, 0, 0, 8'd0));
    @(negedge clk);
    chk("wd_expired", bus.status, st(0, 1, 0, 1, 8'd0));
    pulse_clear(0);
    chk("wd_cleared", bus.status, st(0, 0, 0, 0, 8'd0));

    // nn_done on the expiry cycle wins over the watchdog
    send(32'hB0, 1, 0, 0);
    send(32'hB1, 1, 1, 0);
    send(32'hB2, 1, 2, 0);
    send(32'hB3, 1, 3, 1);
    repeat (10) @(negedge clk);
    bus.nn_done = 1'b1;
    @(negedge clk);
    bus.nn_done = 1'b0;
    chk("done_beats_expiry", bus.status, st(0, 1, 0, 0, 8'd0));
`endif

    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("start_not_pending", {31'd0, start_due}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hps_din_sequencer.md
Name: hps_din_sequencer

Overview:
- Frame loader between the HPS-written data PIO and the MLP core input buffer.
- HPS places a 32-bit word on the data PIO, then toggles a request bit on the control PIO.
- Block writes each word into the input buffer at an incrementing address and toggles an ack bit on the status PIO.
- After FRAME_LEN words it pulses nn_start, tracks the core until nn_done, and reports busy/done/error to the HPS.

Parameters:
DATA_W, 32, width of data words and buffer write data
ADDR_W, 8, buffer address width; FRAME_LEN <= 2**ADDR_W
FRAME_LEN, 16, words per input frame (>= 1)
TIMEOUT_CYC, 65535, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, same domain as the PIOs
reset  in  1  synchronous, active-high reset
din  in  DATA_W  data word from the data PIO out_port
ctrl  in  8  control PIO: [0] req toggle, [1] clear (level), [7:2] ignored
status  out  32  to status PIO input: [0] ack toggle, [1] busy, [2] done, [3] overflow, [4] timeout, [15:8] wr_cnt[7:0], others 0
buf_we  out  1  input buffer write enable, one-cycle pulse
buf_addr  out  ADDR_W  input buffer write address
buf_wdata  out  DATA_W  input buffer write data
nn_start  out  1  one-cycle start pulse to the MLP core
nn_done  in  1  one-cycle completion pulse from the MLP core

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - state=IDLE; wr_cnt=0; req_q=0; ack=0; overflow=0; timeout=0.
- Request detection:
  - req_q <= ctrl[0] every cycle, in every state.
  - new_req = (ctrl[0] != req_q).
  - A request that is not accepted is consumed and never replays.
- States: IDLE, START, RUN, DONE.
- IDLE, on new_req (all outputs registered, visible the cycle after the sampling edge):
  - buf_we=1, buf_addr=wr_cnt, buf_wdata=din; ack toggles.
  - If wr_cnt==FRAME_LEN-1: wr_cnt<=0 and state<=START. Otherwise wr_cnt<=wr_cnt+1.
- START: nn_start=1 for exactly one cycle, starting the cycle after the final buf_we; then state<=RUN.
- START/RUN, on new_req:
  - No write; ack unchanged; overflow<=1 (sticky).
  - nn_done in START is ignored.
- RUN, on nn_done: state<=DONE.
- DONE:
  - done=1.
  - On new_req: same action as IDLE with wr_cnt=0 (write to addr 0, ack toggles, wr_cnt<=1), state<=IDLE.
  - FRAME_LEN==1: state<=START instead of IDLE.
- busy = (state==START || state==RUN). done = (state==DONE). Both are registered.
- Clear (ctrl[1]=1), any state:
  - state<=IDLE; wr_cnt<=0; overflow<=0; timeout<=0; nn_start<=0; buf_we<=0.
  - ack is preserved.
  - Clear has priority over a simultaneous new_req: no write, no ack toggle, request consumed.
- nn_done in IDLE or DONE is ignored. A clear during RUN therefore discards the core's later done.
- buf_addr and buf_wdata hold their last values when buf_we=0.
- wr_cnt never exceeds FRAME_LEN-1. No wrap past the frame boundary.

Optional Feature:
- Macro HPS_DIN_SEQ_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counter clears on entry to RUN and increments each RUN cycle.
  - When it reaches TIMEOUT_CYC with no nn_done: timeout<=1 (sticky), state<=DONE.
  - nn_done in the same cycle as expiry takes precedence: timeout stays 0.
- Undefined: no counter; status[4] is constant 0; RUN exits only on nn_done or clear.

Test Plan:
1. Reset held 3 cycles, then released -> status=0, buf_we=0, nn_start=0, state IDLE.
2. FRAME_LEN=4: four req toggles with din=0x11,0x22,0x33,0x44 -> buf writes (0,0x11) (1,0x22) (2,0x33) (3,0x44); ack toggles 4 times; single nn_start pulse 1 cycle after the addr-3 write; status busy=1.
3. Req toggle during RUN with din=0x55 -> no buf_we, ack unchanged, overflow=1. Then nn_done pulse -> busy=0, done=1, overflow still 1.
4. In DONE, req with din=0xAA -> write (0,0xAA); done=0; status[15:8]=1; state IDLE.
5. After 2 words, assert clear together with a req toggle -> no write, ack unchanged, wr_cnt=0. Next req with din=0x77 -> write (0,0x77).
6. With HPS_DIN_SEQ_TIMEOUT_EN and TIMEOUT_CYC=10: fill frame, withhold nn_done -> 10 RUN cycles later timeout=1, done=1, busy=0. Repeat with nn_done on the expiry cycle -> timeout=0, done=1.
